stopwatch_core: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 87 ++++++++
 rtl/stopwatch_core_if.sv | 18 +
 rtl/sw_tick_gen.sv | 24 ++
 rtl/stopwatch_core.sv | 101 ++++++++++
 tb/tb_stopwatch_core.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and BCD step helpers for the stopwatch timing engine.
// The state encoding is also consumed by the 7-segment display block.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      UP_WAIT   = 2'b00,
      UP_RUN    = 2'b01,
      DOWN_WAIT = 2'b10,
      DOWN_RUN  = 2'b11
   } sw_state_e;

   localparam logic [2:0] SW_NONE     = 3'd0;
   localparam logic [2:0] SW_START    = 3'd1;
   localparam logic [2:0] SW_CLEAR    = 3'd2;
   localparam logic [2:0] SW_LAP      = 3'd3;
   localparam logic [2:0] SW_LAP_ALT  = 3'd4;
   localparam logic [2:0] SW_MODE     = 3'd5;
   localparam logic [2:0] SW_PRESET_M = 3'd6;
   localparam logic [2:0] SW_PRESET_S = 3'd7;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   typedef struct packed {
      logic [3:0] m2;
      logic [3:0] m1;
      logic [2:0] s2;
      logic [3:0] s1;
   } sw_time_t;

   localparam sw_time_t TIME_ZERO = '0;
   localparam sw_time_t TIME_MAX  = '{m2: 4'd9, m1: 4'd9, s2: 3'd5, s1: 4'd9};

   // Out-of-range digits (SEU only) collapse to 0 and never generate a carry/borrow.
   function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] lim,
                                            input logic en);
      if (d > lim)        return 4'd0;
      else if (!en)       return d;
      else if (d == lim)  return 4'd0;
      else                return d + 4'd1;
   endfunction

   function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] lim,
                                            input logic en);
      if (d > lim)        return 4'd0;
      else if (!en)       return d;
      else if (d == 4'd0) return lim;
      else                return d - 4'd1;
   endfunction

   function automatic sw_time_t time_inc(input sw_time_t t);
      logic c1, c2, c3;
      c1 = (t.s1 == BCD_MAX);
      c2 = c1 && (t.s2 == 3'(SEC_TENS_MAX));
      c3 = c2 && (t.m1 == BCD_MAX);
      return '{m2: digit_inc(t.m2, BCD_MAX, c3),
               m1: digit_inc(t.m1, BCD_MAX, c2),
               s2: 3'(digit_inc({1'b0, t.s2}, SEC_TENS_MAX, c1)),
               s1: digit_inc(t.s1, BCD_MAX, 1'b1)};
   endfunction

   function automatic sw_time_t time_dec(input sw_time_t t);
      logic b1, b2, b3;
      b1 = (t.s1 == 4'd0);
      b2 = b1 && (t.s2 == 3'd0);
      b3 = b2 && (t.m1 == 4'd0);
      return '{m2: digit_dec(t.m2, BCD_MAX, b3),
               m1: digit_dec(t.m1, BCD_MAX, b2),
               s2: 3'(digit_dec({1'b0, t.s2}, SEC_TENS_MAX, b1)),
               s1: digit_dec(t.s1, BCD_MAX, 1'b1)};
   endfunction

   function automatic sw_time_t preset_min(input sw_time_t t);
      return '{m2: digit_inc(t.m2, BCD_MAX, t.m1 == BCD_MAX),
               m1: digit_inc(t.m1, BCD_MAX, 1'b1),
               s2: t.s2,
               s1: t.s1};
   endfunction

   function automatic sw_time_t preset_sec(input sw_time_t t);
      return '{m2: t.m2,
               m1: t.m1,
               s2: 3'(digit_inc({1'b0, t.s2}, SEC_TENS_MAX, 1'b1)),
               s1: t.s1};
   endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Button-code input and display-facing state/digit outputs of the stopwatch core.
// switch_in carries one code for one cycle per press; the outputs are always valid.
interface stopwatch_core_if;
   import stopwatch_pkg::*;

   logic [2:0] switch_in;
   sw_state_e  current_state;
   logic [3:0] min_cnt2;
   logic [3:0] min_cnt1;
   logic [2:0] sec_cnt2;
   logic [3:0] sec_cnt1;
   logic       done;

   modport master (output switch_in,
                   input  current_state, min_cnt2, min_cnt1, sec_cnt2, sec_cnt1, done);
   modport slave  (input  switch_in,
                   output current_state, min_cnt2, min_cnt1, sec_cnt2, sec_cnt1, done);
endinterface

// File: rtl/sw_tick_gen.sv
// 1 Hz step prescaler: counts 0..TICK_DIV-1 while enabled, tick on the last count.
// clear restarts the period so the first step lands exactly TICK_DIV cycles later.
module sw_tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);
   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = enable && (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     cnt_q <= '0;
      else if (clear)   cnt_q <= '0;
      else if (enable)  cnt_q <= tick ? '0 : cnt_q + CW'(1);
   end
endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/timer engine: mode/run FSM plus MM:SS BCD counters stepped by sw_tick_gen.
// Buttons take priority over a coincident tick; all outputs are registered.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input logic             clk,
   input logic             reset_n,
   stopwatch_core_if.slave sw_if
);
   sw_state_e  state_q;
   sw_time_t   time_q;
   logic       done_q;
   sw_time_t   up_d, dn_d, pre_m_d, pre_s_d;
   logic [2:0] code;
   logic       tick, run_en, tick_clr;

   assign code     = sw_if.switch_in;
   assign run_en   = (state_q == UP_RUN) || (state_q == DOWN_RUN);
   // Every run-state entry comes from a start press, so start/clear restart the prescaler.
   assign tick_clr = (code == SW_START) || (code == SW_CLEAR);

   assign up_d    = time_inc(time_q);
   assign dn_d    = time_dec(time_q);
   assign pre_m_d = preset_min(time_q);
   assign pre_s_d = preset_sec(time_q);

   sw_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (run_en),
      .clear   (tick_clr),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= UP_WAIT;
         time_q  <= TIME_ZERO;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            UP_WAIT: begin
               if (code == SW_START) state_q <= UP_RUN;
               else if (code == SW_MODE) begin
                  state_q <= DOWN_WAIT;
                  time_q  <= TIME_ZERO;
               end else if (code == SW_CLEAR) time_q <= TIME_ZERO;
            end
            UP_RUN: begin
               if (code == SW_START) state_q <= UP_WAIT;
               else if (code == SW_CLEAR) begin
                  state_q <= UP_WAIT;
                  time_q  <= TIME_ZERO;
               end else if (tick) begin
                  if (time_q == TIME_MAX) begin
                     state_q <= UP_WAIT;
                     done_q  <= 1'b1;
                  end else time_q <= up_d;
               end
            end
            DOWN_WAIT: begin
               if (code == SW_START) begin
                  if (time_q != TIME_ZERO) state_q <= DOWN_RUN;
               end else if (code == SW_MODE) begin
                  state_q <= UP_WAIT;
                  time_q  <= TIME_ZERO;
               end else if (code == SW_CLEAR)    time_q <= TIME_ZERO;
               else if (code == SW_PRESET_M)     time_q <= pre_m_d;
               else if (code == SW_PRESET_S)     time_q <= pre_s_d;
            end
            DOWN_RUN: begin
               if (code == SW_START) state_q <= DOWN_WAIT;
               else if (code == SW_CLEAR) begin
                  state_q <= DOWN_WAIT;
                  time_q  <= TIME_ZERO;
               end else if (tick) begin
                  if (time_q == TIME_ZERO) state_q <= DOWN_WAIT;
                  else begin
                     time_q <= dn_d;
                     if (dn_d == TIME_ZERO) begin
                        state_q <= DOWN_WAIT;
                        done_q  <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= UP_WAIT;
         endcase
      end
   end

   assign sw_if.current_state = state_q;
   assign sw_if.min_cnt2      = time_q.m2;
   assign sw_if.min_cnt1      = time_q.m1;
   assign sw_if.sec_cnt2      = time_q.s2;
   assign sw_if.sec_cnt1      = time_q.s1;
   assign sw_if.done          = done_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core with TICK_DIV=4: button table plus count/reset sequences.
// Expected displays come from a seconds-to-MM:SS model pushed to a queue and popped on sampling.
module tb_stopwatch_core;
   import stopwatch_pkg::*;

   localparam int unsigned TICK_DIV = 4;
   localparam int NVEC = 29;

   typedef logic [17:0] obs_t;
   typedef struct {
      logic [2:0] code;
      sw_state_e  st;
      int         secs;
   } vec_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   stopwatch_core_if sw_if();

   stopwatch_core #(.TICK_DIV(TICK_DIV)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sw_if   (sw_if)
   );

   always #5 clk = ~clk;

   obs_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   vec_t vecs[NVEC];

   always @(posedge clk) if (sw_if.done) done_cnt++;

   function automatic obs_t model(input sw_state_e st, input int secs, input logic done);
      return {st, 4'(secs / 600), 4'((secs / 60) % 10), 3'((secs % 60) / 10),
              4'(secs % 10), done};
   endfunction

   task automatic predict(input sw_state_e st, input int secs, input logic done);
      exp_q.push_back(model(st, secs, done));
   endtask

   task automatic compare(input string name);
      obs_t got, exp;
      got = {sw_if.current_state, sw_if.min_cnt2, sw_if.min_cnt1, sw_if.sec_cnt2,
             sw_if.sec_cnt1, sw_if.done};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got state=%0d %0d%0d:%0d%0d done=%0b, expected state=%0d %0d%0d:%0d%0d done=%0b",
                  name, got[17:16], got[15:12], got[11:8], got[7:5], got[4:1], got[0],
                  exp[17:16], exp[15:12], exp[11:8], exp[7:5], exp[4:1], exp[0]);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic press(input logic [2:0] code);
      sw_if.switch_in = code;
      @(negedge clk);
      sw_if.switch_in = SW_NONE;
   endtask

   task automatic press_chk(input string name, input logic [2:0] code, input sw_state_e st,
                            input int secs, input logic done);
      predict(st, secs, done);
      press(code);
      compare(name);
   endtask

   task automatic idle_chk(input string name, input int n, input sw_state_e st,
                           input int secs, input logic done);
      predict(st, secs, done);
      repeat (n) @(negedge clk);
      compare(name);
   endtask

   initial begin
      vecs[0]  = '{3'd3, UP_WAIT,   0};
      vecs[1]  = '{3'd4, UP_WAIT,   0};
      vecs[2]  = '{3'd6, UP_WAIT,   0};
      vecs[3]  = '{3'd7, UP_WAIT,   0};
      vecs[4]  = '{3'd5, DOWN_WAIT, 0};
      vecs[5]  = '{3'd6, DOWN_WAIT, 60};
      vecs[6]  = '{3'd7, DOWN_WAIT, 70};
      vecs[7]  = '{3'd3, DOWN_WAIT, 70};
      vecs[8]  = '{3'd1, DOWN_RUN,  70};
      vecs[9]  = '{3'd6, DOWN_RUN,  70};
      vecs[10] = '{3'd7, DOWN_RUN,  70};
      vecs[11] = '{3'd3, DOWN_RUN,  70};
      vecs[12] = '{3'd1, DOWN_WAIT, 70};   // lands on the tick cycle: button wins
      vecs[13] = '{3'd2, DOWN_WAIT, 0};
      vecs[14] = '{3'd1, DOWN_WAIT, 0};
      vecs[15] = '{3'd7, DOWN_WAIT, 10};
      vecs[16] = '{3'd7, DOWN_WAIT, 20};
      vecs[17] = '{3'd7, DOWN_WAIT, 30};
      vecs[18] = '{3'd7, DOWN_WAIT, 40};
      vecs[19] = '{3'd7, DOWN_WAIT, 50};
      vecs[20] = '{3'd7, DOWN_WAIT, 0};
      vecs[21] = '{3'd7, DOWN_WAIT, 10};
      vecs[22] = '{3'd1, DOWN_RUN,  10};
      vecs[23] = '{3'd2, DOWN_WAIT, 0};
      vecs[24] = '{3'd5, UP_WAIT,   0};
      vecs[25] = '{3'd1, UP_RUN,    0};
      vecs[26] = '{3'd5, UP_RUN,    0};
      vecs[27] = '{3'd6, UP_RUN,    0};
      vecs[28] = '{3'd2, UP_WAIT,   0};

      sw_if.switch_in = SW_NONE;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      predict(UP_WAIT, 0, 1'b0);
      compare("reset_values");
      reset_n = 1'b1;
      idle_chk("after_reset", 1, UP_WAIT, 0, 1'b0);

      for (int i = 0; i < NVEC; i++)
         press_chk($sformatf("vec%0d", i), vecs[i].code, vecs[i].st, vecs[i].secs, 1'b0);

      press_chk("wrap_mode", SW_MODE, DOWN_WAIT, 0, 1'b0);
      for (int i = 0; i < 98; i++) press(SW_PRESET_M);
      press_chk("min_99", SW_PRESET_M, DOWN_WAIT, 5940, 1'b0);
      press_chk("min_wrap", SW_PRESET_M, DOWN_WAIT, 0, 1'b0);
      press_chk("back_up", SW_MODE, UP_WAIT, 0, 1'b0);

      press_chk("up_start", SW_START, UP_RUN, 0, 1'b0);
      idle_chk("up_no_early", 3, UP_RUN, 0, 1'b0);
      idle_chk("up_first", 1, UP_RUN, 1, 1'b0);
      idle_chk("up_0009", 32, UP_RUN, 9, 1'b0);
      idle_chk("up_0010", 4, UP_RUN, 10, 1'b0);
      idle_chk("up_0100", 200, UP_RUN, 60, 1'b0);
      idle_chk("up_9958", 23752, UP_RUN, 5998, 1'b0);
      idle_chk("up_9959", 4, UP_RUN, 5999, 1'b0);
      idle_chk("up_sat", 4, UP_WAIT, 5999, 1'b1);
      idle_chk("up_sat_hold", 1, UP_WAIT, 5999, 1'b0);
      check_int("done_count_up", done_cnt, 1);
      press_chk("up_clear", SW_CLEAR, UP_WAIT, 0, 1'b0);

      press_chk("col_start", SW_START, UP_RUN, 0, 1'b0);
      idle_chk("col_pre", 3, UP_RUN, 0, 1'b0);
      press_chk("col_stop", SW_START, UP_WAIT, 0, 1'b0);
      press_chk("col_restart", SW_START, UP_RUN, 0, 1'b0);
      press_chk("col_lap", SW_LAP, UP_RUN, 0, 1'b0);
      idle_chk("col_wait", 2, UP_RUN, 0, 1'b0);
      idle_chk("col_step", 1, UP_RUN, 1, 1'b0);
      press_chk("col_clear", SW_CLEAR, UP_WAIT, 0, 1'b0);

      press_chk("dn_mode", SW_MODE, DOWN_WAIT, 0, 1'b0);
      press_chk("dn_pm", SW_PRESET_M, DOWN_WAIT, 60, 1'b0);
      press(SW_PRESET_S);
      press(SW_PRESET_S);
      press_chk("dn_0130", SW_PRESET_S, DOWN_WAIT, 90, 1'b0);
      press_chk("dn_start", SW_START, DOWN_RUN, 90, 1'b0);
      idle_chk("dn_0100", 120, DOWN_RUN, 60, 1'b0);
      idle_chk("dn_borrow", 4, DOWN_RUN, 59, 1'b0);
      idle_chk("dn_0001", 235, DOWN_RUN, 1, 1'b0);
      idle_chk("dn_zero", 1, DOWN_WAIT, 0, 1'b1);
      idle_chk("dn_done_once", 1, DOWN_WAIT, 0, 1'b0);
      check_int("done_count_dn", done_cnt, 2);
      press_chk("dn_start_zero", SW_START, DOWN_WAIT, 0, 1'b0);
      idle_chk("dn_stay", 4, DOWN_WAIT, 0, 1'b0);

      press_chk("rst_pm", SW_PRESET_M, DOWN_WAIT, 60, 1'b0);
      press_chk("rst_start", SW_START, DOWN_RUN, 60, 1'b0);
      idle_chk("rst_0045", 60, DOWN_RUN, 45, 1'b0);
      #2 reset_n = 1'b0;
      predict(UP_WAIT, 0, 1'b0);
      #1 compare("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      idle_chk("post_reset", 1, UP_WAIT, 0, 1'b0);
      press_chk("post_lap", SW_LAP_ALT, UP_WAIT, 0, 1'b0);
      idle_chk("post_idle", 8, UP_WAIT, 0, 1'b0);
      check_int("done_count_rst", done_cnt, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
